// File: rtl/instrument_frame_decoder.sv
// Marker-framed UART packet decoder: collects NUM_BYTES 7-bit payload bytes and commits NUM_CH channels atomically.
// Optional drum foot-pedal remap on channel DRUM_CH when INSTR_DRUM_DECODE_EN is defined.
module instrument_frame_decoder #(
  parameter int NUM_BYTES   = 3,
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 5,
  parameter int DRUM_CH     = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]        ch_changed,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic [7:0]               err_count
);
  localparam int PW = 7 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  if (NUM_BYTES < 1 || NUM_BYTES > 8) begin : g_bad_nb
    $error("NUM_BYTES must be 1..8");
  end
  if (NUM_CH * CH_W > PW) begin : g_bad_w
    $error("NUM_CH*CH_W exceeds payload width");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_to
    $error("TIMEOUT_CYC must be >= 2");
  end

  typedef enum logic {S_COLLECT, S_HUNT} st_e;

  st_e                          st_q, st_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [PW-1:0]                buf_q, buf_d;
  logic [TW-1:0]                idle_q, idle_d;
  logic [NUM_CH*CH_W-1:0]       ch_q, ch_d;
  logic [NUM_CH-1:0]            chg_q, chg_d;
  logic                         fv_q, fe_q;
  logic [7:0]                   ec_q, ec_d;

  logic                         last, marker, expire, commit, err;
  logic [PW-1:0]                pl;
  logic [NUM_CH-1:0][CH_W-1:0]  new_ch;
  logic                         unused_pl;

  assign last   = (idx_q == IW'(NUM_BYTES - 1));
  assign marker = rx_data[7];
  assign expire = (st_q == S_COLLECT) && (idx_q != '0) && !rx_valid &&
                  (idle_q == TW'(TIMEOUT_CYC - 1));
  assign commit = (st_q == S_COLLECT) && rx_valid && marker && last;
  // marker on a non-final byte is a short frame, no marker on the final byte a long one
  assign err    = ((st_q == S_COLLECT) && rx_valid && (marker != last)) || expire;

  always_comb begin
    pl = buf_q;
    pl[7*(NUM_BYTES-1) +: 7] = rx_data[6:0];
  end
  assign unused_pl = ^pl;

`ifdef INSTR_DRUM_DECODE_EN
  function automatic logic [CH_W-1:0] drum_map(input logic [3:0] n);
    case (n)
      4'hF:    return CH_W'(5'h11);
      4'hE:    return CH_W'(5'h12);
      4'hD:    return CH_W'(5'h14);
      4'hB:    return CH_W'(5'h18);
      default: return CH_W'(n);
    endcase
  endfunction
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef INSTR_DRUM_DECODE_EN
    if (k == DRUM_CH) begin : g_drum
      assign new_ch[k] = drum_map(pl[k*CH_W +: 4]);
    end else begin : g_pass
      assign new_ch[k] = pl[k*CH_W +: CH_W];
    end
`else
    assign new_ch[k] = pl[k*CH_W +: CH_W];
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_COLLECT;
      idx_q  <= '0;
      buf_q  <= '0;
      idle_q <= '0;
      ch_q   <= '0;
      chg_q  <= '0;
      fv_q   <= 1'b0;
      fe_q   <= 1'b0;
      ec_q   <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      buf_q  <= buf_d;
      idle_q <= idle_d;
      ch_q   <= ch_d;
      chg_q  <= chg_d;
      fv_q   <= commit;
      fe_q   <= err;
      ec_q   <= ec_d;
    end
  end

  // next-state
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    buf_d  = buf_q;
    idle_d = idle_q;
    case (st_q)
      S_COLLECT: begin
        if (rx_valid) begin
          idle_d = '0;
          if (marker) begin
            idx_d = '0;
          end else if (last) begin
            st_d  = S_HUNT;
            idx_d = '0;
          end else begin
            buf_d[7*idx_q +: 7] = rx_data[6:0];
            idx_d = idx_q + 1'b1;
          end
        end else if (idx_q != '0) begin
          if (expire) begin
            idx_d  = '0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      S_HUNT: begin
        idle_d = '0;
        if (rx_valid && marker) begin
          st_d  = S_COLLECT;
          idx_d = '0;
        end
      end
      default: st_d = S_COLLECT;
    endcase
  end

  // output next values
  always_comb begin
    ch_d = commit ? new_ch : ch_q;
    for (int k = 0; k < NUM_CH; k++)
      chg_d[k] = commit && (new_ch[k] != ch_q[k*CH_W +: CH_W]);
    ec_d = (err && ec_q != 8'hFF) ? ec_q + 8'd1 : ec_q;
  end

  assign ch_data     = ch_q;
  assign ch_changed  = chg_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign err_count   = ec_q;
endmodule

// File: tb/tb_instrument_frame_decoder.sv
// Directed bench for instrument_frame_decoder (defaults, TIMEOUT_CYC=100).
module tb_instrument_frame_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [14:0] ch_data;
  logic [2:0]  ch_changed;
  logic        frame_valid, frame_err;
  logic [7:0]  err_count;

  int n_tot = 0;
  int n_bad = 0;

  instrument_frame_decoder #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_data(ch_data), .ch_changed(ch_changed), .frame_valid(frame_valid),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef INSTR_DRUM_DECODE_EN
  localparam logic [4:0] DRUM_EXP = 5'h12;
`else
  localparam logic [4:0] DRUM_EXP = 5'h0E;
`endif
  localparam logic [14:0] FR_A = {5'h1F, 5'h0A, 5'h15};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one byte; returns 1ns after the edge that samples it
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    idle(3);
    chk("rst_ch", ch_data, 0);
    chk("rst_chg", ch_changed, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ec", err_count, 0);
    rst_n = 1'b1;
    idle(2);

    // good frame
    send(8'h55); send(8'h7A);
    chk("mid_fv", frame_valid, 0);
    send(8'h81);
    chk("good_ch", ch_data, FR_A);
    chk("good_fv", frame_valid, 1);
    chk("good_chg", ch_changed, 3'b111);
    idle(1);
    chk("good_fv_pulse", frame_valid, 0);
    chk("good_chg_pulse", ch_changed, 0);
    send(8'h55); send(8'h7A); send(8'h81);
    chk("same_fv", frame_valid, 1);
    chk("same_chg", ch_changed, 3'b000);

    // drum frame, raw ch1=0x0E
    send(8'h40); send(8'h03); send(8'h80);
    chk("drum_ch1", ch_data[9:5], DRUM_EXP);
    chk("drum_ch", ch_data, {5'h00, DRUM_EXP, 5'h00});
    chk("drum_chg", ch_changed, 3'b111);

    // short frame
    send(8'h55); send(8'h81);
    chk("short_fe", frame_err, 1);
    chk("short_fv", frame_valid, 0);
    chk("short_ec", err_count, 1);
    chk("short_ch", ch_data, {5'h00, DRUM_EXP, 5'h00});
    idle(1);
    chk("short_fe_pulse", frame_err, 0);
    send(8'h55); send(8'h7A); send(8'h81);
    chk("after_short_ch", ch_data, FR_A);
    chk("after_short_fv", frame_valid, 1);

    // long frame then hunt
    send(8'h01); send(8'h02); send(8'h03);
    chk("long_fe", frame_err, 1);
    chk("long_ec", err_count, 2);
    send(8'h04);
    chk("hunt_fe", frame_err, 0);
    send(8'h81);
    chk("hunt_fv", frame_valid, 0);
    chk("hunt_fe2", frame_err, 0);
    chk("hunt_ec", err_count, 2);
    send(8'h55); send(8'h7A); send(8'h81);
    chk("after_long_fv", frame_valid, 1);
    chk("after_long_ch0", ch_data[4:0], 5'h15);

    // timeout after 100 idle cycles
    send(8'h55);
    idle(99);
    chk("to_early_fe", frame_err, 0);
    idle(1);
    chk("to_fe", frame_err, 1);
    chk("to_ec", err_count, 3);
    send(8'h7A);
    chk("to_fe_pulse", frame_err, 0);
    send(8'h81);
    chk("to_short_fe", frame_err, 1);
    chk("to_short_ec", err_count, 4);
    chk("to_short_fv", frame_valid, 0);

    // byte coincident with expiry wins
    send(8'h55);
    idle(99);
    send(8'h7A);
    chk("to_race_fe", frame_err, 0);
    idle(1);
    chk("to_race_fe2", frame_err, 0);
    send(8'h81);
    chk("to_race_fv", frame_valid, 1);
    chk("to_race_ec", err_count, 4);

    // saturation: each lone marker byte is a short frame
    for (int i = 0; i < 260; i++) send(8'h81);
    chk("sat_ec", err_count, 255);
    chk("sat_ch", ch_data, FR_A);

    // reset mid-frame
    send(8'h55);
    rst_n = 1'b0;
    #2;
    chk("mrst_ch", ch_data, 0);
    chk("mrst_ec", err_count, 0);
    chk("mrst_fv", frame_valid, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(8'h55); send(8'h7A); send(8'h81);
    chk("mrst_commit_ch", ch_data, FR_A);
    chk("mrst_commit_chg", ch_changed, 3'b111);
    chk("mrst_commit_fv", frame_valid, 1);
    chk("mrst_commit_ec", err_count, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/instrument_frame_decoder.md
# instrument_frame_decoder

Parametrised framed-controller decoder sitting between `async_receiver` and the per-instrument note logic. It assembles multi-byte marker-framed packets from the UART byte stream into NUM_CH channel fields of CH_W bits, and commits all channels atomically on a good frame. It detects framing errors and inter-byte timeouts, resynchronises, and reports per-channel change flags. An optional drum foot-pedal remap is applied to one channel.

## Interface
Parameters:
- NUM_BYTES, 3: bytes per frame (1..8); each byte carries 7 payload bits, giving a 7·NUM_BYTES-bit payload.
- NUM_CH, 3: number of channels.
- CH_W, 5: bits per channel; NUM_CH·CH_W ≤ 7·NUM_BYTES (elaboration check); unused upper payload bits are ignored.
- DRUM_CH, 1: channel index remapped when drum decode is compiled in (requires CH_W ≥ 5).
- TIMEOUT_CYC, 65535: max idle cycles between bytes inside a frame (≥ 2).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- rx_data, in, 8: byte from `async_receiver`.
- rx_valid, in, 1: one-cycle strobe; rx_data is valid.
- ch_data, out, NUM_CH·CH_W: committed channels, ch k at [k·CH_W +: CH_W].
- ch_changed, out, NUM_CH: one-cycle mask of channels whose committed value differs from the previous commit.
- frame_valid, out, 1: one-cycle pulse on commit.
- frame_err, out, 1: one-cycle pulse on any framing/timeout error.
- err_count, out, 8: saturating error counter (stops at 255).

## Operation
- Framing: byte bit7 is the marker. Bytes 0..NUM_BYTES-2 have bit7=0; the last byte has bit7=1. Byte k bits[6:0] → payload[7k+6:7k].
- States: COLLECT (byte index idx, 0..NUM_BYTES-1) and HUNT.
- COLLECT, rx_valid:
  - bit7=1, idx=NUM_BYTES-1: commit payload, pulse frame_valid, idx←0.
  - bit7=1, idx<NUM_BYTES-1: short frame. Discard, pulse frame_err, idx←0 (the marker byte closes the bad frame).
  - bit7=0, idx=NUM_BYTES-1: long frame. Discard, pulse frame_err, go to HUNT.
  - bit7=0, otherwise: store, idx←idx+1.
- HUNT: discard bytes until one with bit7=1 is seen, then COLLECT idx=0; no further errors are counted while hunting.
- Timeout: an idle counter runs in COLLECT while idx≠0. It is cleared on every rx_valid. On reaching TIMEOUT_CYC: discard, pulse frame_err, idx←0. If rx_valid and expiry coincide, the byte wins and no timeout is raised.
- Commit: ch_data takes the payload fields (drum-remapped if enabled); ch_changed[k]=1 when the new ch k ≠ the old ch k. Partial frames never alter ch_data.
- err_count increments on each frame_err pulse and saturates at 255.

## Timing
- Reset values: ch_data=0, ch_changed=0, frame_valid=0, frame_err=0, err_count=0, state COLLECT idx=0, idle counter=0.
- Latency: ch_data, ch_changed, and frame_valid update on the clock edge after the cycle in which the final byte's rx_valid is sampled (1 cycle).
- frame_err is asserted on the edge after the offending byte, or the edge after the timeout expiry.
- Back-to-back rx_valid on consecutive cycles is fully supported; no backpressure.
- Reset mid-frame discards the partial frame; the next byte is treated as byte 0.

## Configuration
- INSTR_DRUM_DECODE_EN defined: at commit, channel DRUM_CH low nibble n is remapped:
  - n=0xF→0x11, 0xE→0x12, 0xD→0x14, 0xB→0x18;
  - any other n→{1'b0,n} (zero-extended to CH_W);
  - raw bits above the nibble are ignored.
- ch_changed compares the remapped values.
- Not defined: DRUM_CH passes through unmodified like every other channel.

## Test plan
- Good frame, defaults: bytes 0x55, 0x7A, 0x81 → one cycle later ch0=0x15, ch1=0x0A, ch2=0x1F, frame_valid=1 for one cycle, ch_changed=3'b111; resending the same frame → ch_changed=3'b000.
- Drum decode: bytes 0x40, 0x03, 0x80 (raw ch1=0x0E) → ch1=0x12 with INSTR_DRUM_DECODE_EN; ch1=0x0E without it.
- Short frame: bytes 0x55, 0x81 → frame_err pulse, err_count=1, ch_data unchanged; a following 0x55, 0x7A, 0x81 commits normally.
- Long frame: 0x01, 0x02, 0x03, 0x04, then 0x81 → one frame_err, HUNT, no commit. The next 0x55, 0x7A, 0x81 commits ch0=0x15.
- Timeout, TIMEOUT_CYC=100: 0x55, 100 idle cycles → frame_err; then 0x7A, 0x81 → short-frame error (err_count=2), no commit. A byte at cycle 99 → no error.
- Reset mid-frame: 0x55, assert rst_n=0, release, send 0x55, 0x7A, 0x81 → outputs zero during reset, then a clean commit; err_count=0.
